lcd_power_sequencer: RTL and testbench

//  Panel power/enable controller for the LVDS LCD path. Orders panel VDD, LVDS video enable
//  (gates timing generator + serializer reset) and backlight enable/PWM per panel datasheet

---
 rtl/lcd_power_sequencer_pkg.sv | 63 ++++++
 rtl/lcd_power_sequencer_if.sv | 45 ++++
 rtl/lcd_power_sequencer_backlight_pwm.sv | 45 ++++
 rtl/lcd_power_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_lcd_power_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_power_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pwrseq_pkg
//   Shared definitions for the LVDS panel power sequencer:
//     - state encodings (S_OFF = 0 .. S_HOLD = 6), visible on state_o
//     - default timer tick (clk cycles per 1 ms) and PWM resolution
//     - rails_t / rails_for(): the supply/video/backlight pattern of each state
//   Optional backlight PWM is selected with the BACKLIGHT_PWM_EN macro in the
//   top level; nothing in this package depends on it.
// -----------------------------------------------------------------------------
package lcd_pwrseq_pkg;

  // 100 MHz system clock -> 100000 cycles per millisecond tick
  localparam int MS_TICK          = 100000;
  localparam int PWM_BITS_DEFAULT = 8;

  // Millisecond counter width; the counter saturates, so it only has to hold
  // the longest delay the sequencer waits for (T_OFF_MS by default).
  localparam int MS_CNT_W = 16;

  // State encodings, kept as plain constants so state_o stays a fixed,
  // documented 3-bit code for software and older tooling.
  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_VDD    = 3'd1;
  localparam logic [2:0] S_VID    = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_BLOFF  = 3'd4;
  localparam logic [2:0] S_VIDOFF = 3'd5;
  localparam logic [2:0] S_HOLD   = 3'd6;

  // Panel rail pattern driven in a given state
  typedef struct packed {
    logic vdd;
    logic video;
    logic led;
  } rails_t;

  // Rail pattern per state. Every pattern respects the ordering
  // led -> video -> vdd, so registering rails_for(next_state) keeps the
  // invariant on every cycle, including the lock-loss shortcut.
  function automatic rails_t rails_for(input logic [2:0] s);
    rails_t r;
    r = '0;
    case (s)
      S_VDD, S_VIDOFF: begin
        r.vdd = 1'b1;
      end
      S_VID, S_BLOFF: begin
        r.vdd   = 1'b1;
        r.video = 1'b1;
      end
      S_RUN: begin
        r.vdd   = 1'b1;
        r.video = 1'b1;
        r.led   = 1'b1;
      end
      default: begin
        r = '0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcd_power_sequencer_if.sv
// -----------------------------------------------------------------------------
// lcd_power_sequencer_if
//   Bundle of the request/status signals between a panel host (master) and the
//   power sequencer (slave).
//   Host -> sequencer:
//     enable_req   level, 1 = panel on requested
//     lock         pixel/serializer clock lock, already synchronised to clk
//     frame_start  one-cycle pulse at frame start, already synchronised to clk
//     brightness   backlight duty, value / 2^PWM_BITS
//   Sequencer -> host / panel:
//     panel_vdd_en, video_en, led_en, led_pwm   panel rail controls
//     ready        1 only while the panel is fully on
//     fault        sticky: clock lock lost while video was enabled
//     state_o      current state code (see lcd_pwrseq_pkg)
// -----------------------------------------------------------------------------
interface lcd_power_sequencer_if
  import lcd_pwrseq_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
);

  logic                enable_req;
  logic                lock;
  logic                frame_start;
  logic [PWM_BITS-1:0] brightness;

  logic                panel_vdd_en;
  logic                video_en;
  logic                led_en;
  logic                led_pwm;
  logic                ready;
  logic                fault;
  logic [2:0]          state_o;

  modport master (
    output enable_req, lock, frame_start, brightness,
    input  panel_vdd_en, video_en, led_en, led_pwm, ready, fault, state_o
  );

  modport slave (
    input  enable_req, lock, frame_start, brightness,
    output panel_vdd_en, video_en, led_en, led_pwm, ready, fault, state_o
  );

endinterface

// File: rtl/lcd_power_sequencer_backlight_pwm.sv
// -----------------------------------------------------------------------------
// lcd_backlight_pwm
//   Backlight PWM generator, only instantiated when BACKLIGHT_PWM_EN is defined.
//   A free-running PWM_BITS counter sets the period (2^PWM_BITS clk). The duty
//   value is captured from brightness only when the counter wraps to 0, so a
//   brightness change never produces a runt or stretched pulse mid-period.
//   Ports:
//     clk         system clock
//     rst         asynchronous, active-low reset (counter and duty to 0)
//     brightness  requested duty, value / 2^PWM_BITS
//     led_en      backlight enable; PWM output is forced low when 0
//     led_pwm     led_en && (counter < duty); duty 0 gives a constant 0
// -----------------------------------------------------------------------------
module lcd_backlight_pwm
  import lcd_pwrseq_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                led_en,
  output logic                led_pwm
);

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty;

  // Counter runs regardless of led_en so the period stays phase-continuous;
  // duty is reloaded on the edge where the counter rolls over to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      duty <= '0;
    end else begin
      cnt <= cnt + PWM_BITS'(1);
      if (cnt == '1) begin
        duty <= brightness;
      end
    end
  end

  assign led_pwm = led_en && (cnt < duty);

endmodule

// File: rtl/lcd_power_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_power_sequencer
//   Panel power/enable controller for the LVDS LCD path. Brings up panel VDD,
//   then the LVDS video path, then the backlight (aligned to a frame start),
//   and tears them down in the reverse order with the panel datasheet delays.
//   Loss of clock lock while video is enabled forces an immediate shutdown of
//   backlight and video and sets a sticky fault flag.
//
//   Configuration macro: BACKLIGHT_PWM_EN
//     defined   -> led_pwm comes from lcd_backlight_pwm (duty = brightness)
//     undefined -> led_pwm simply follows led_en, brightness is unused
//
//   Ports:
//     clk   system clock, all logic on posedge
//     rst   asynchronous, active-low reset
//     bus   lcd_power_sequencer_if.slave:
//             in : enable_req, lock, frame_start, brightness
//             out: panel_vdd_en, video_en, led_en, led_pwm, ready, fault, state_o
//
//   Delays are given in ms; TICK_DIV is clk cycles per ms. A delay of T ms is
//   complete exactly T*TICK_DIV clk edges after state entry (T=0 -> 1 edge).
// -----------------------------------------------------------------------------
module lcd_power_sequencer
  import lcd_pwrseq_pkg::*;
#(
  parameter int TICK_DIV   = MS_TICK,
  parameter int T_VDD_MS   = 10,
  parameter int T_VIDEO_MS = 200,
  parameter int T_BL_MS    = 200,
  parameter int T_PWR_MS   = 10,
  parameter int T_OFF_MS   = 500,
  parameter int PWM_BITS   = PWM_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_power_sequencer_if.slave bus
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [MS_CNT_W:0] T_VDD_C   = (MS_CNT_W + 1)'(T_VDD_MS);
  localparam logic [MS_CNT_W:0] T_VIDEO_C = (MS_CNT_W + 1)'(T_VIDEO_MS);
  localparam logic [MS_CNT_W:0] T_BL_C    = (MS_CNT_W + 1)'(T_BL_MS);
  localparam logic [MS_CNT_W:0] T_PWR_C   = (MS_CNT_W + 1)'(T_PWR_MS);
  localparam logic [MS_CNT_W:0] T_OFF_C   = (MS_CNT_W + 1)'(T_OFF_MS);

  logic [2:0]          state;
  logic [2:0]          state_next;
  logic [PRE_W-1:0]    pre_cnt;
  logic [MS_CNT_W-1:0] ms_cnt;
  logic [MS_CNT_W:0]   ms_done;
  logic                pre_wrap;
  logic                entering;
  logic                lock_fault;
  rails_t              rails_q;
  logic                ready_q;
  logic                fault_q;
  logic                led_pwm_w;

  // ms_done is the number of whole milliseconds completed once the coming
  // edge has been counted. Comparing it against T therefore fires on exactly
  // edge T*TICK_DIV after entry, and T=0 fires on the first edge.
  assign pre_wrap = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign ms_done  = {1'b0, ms_cnt} + {{MS_CNT_W{1'b0}}, pre_wrap};
  assign entering = (state_next != state);

  // Next-state logic. Lock loss is checked first in every powered state so it
  // beats enable_req; in S_VID an abort also beats a qualifying frame_start.
  // Only lock loss with video enabled (S_VID/S_RUN/S_BLOFF) raises the fault.
  always_comb begin
    state_next = state;
    lock_fault = 1'b0;
    case (state)
      S_OFF: begin
        if (bus.enable_req && bus.lock) begin
          state_next = S_VDD;
        end
      end
      S_VDD: begin
        if (!bus.lock || !bus.enable_req) begin
          state_next = S_VIDOFF;
        end else if (ms_done >= T_VDD_C) begin
          state_next = S_VID;
        end
      end
      S_VID: begin
        if (!bus.lock) begin
          state_next = S_VIDOFF;
          lock_fault = 1'b1;
        end else if (!bus.enable_req) begin
          state_next = S_VIDOFF;
        end else if (bus.frame_start && (ms_done >= T_VIDEO_C)) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!bus.lock) begin
          state_next = S_VIDOFF;
          lock_fault = 1'b1;
        end else if (!bus.enable_req) begin
          state_next = S_BLOFF;
        end
      end
      S_BLOFF: begin
        if (!bus.lock) begin
          state_next = S_VIDOFF;
          lock_fault = 1'b1;
        end else if (ms_done >= T_BL_C) begin
          state_next = S_VIDOFF;
        end
      end
      S_VIDOFF: begin
        if (ms_done >= T_PWR_C) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ms_done >= T_OFF_C) begin
          state_next = S_OFF;
        end
      end
      default: begin
        state_next = S_OFF;
      end
    endcase
  end

  // Prescaler + millisecond counter, restarted on every state change. The
  // ms counter saturates so an indefinite wait in S_VID cannot wrap it back
  // below the video delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else if (entering) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else if (pre_wrap) begin
      pre_cnt <= '0;
      if (ms_cnt != '1) begin
        ms_cnt <= ms_cnt + MS_CNT_W'(1);
      end
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // State and all status outputs are registered from state_next, so every
  // output changes on the same edge as the state itself. The fault flag is
  // only cleared when a new power-up starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_OFF;
      rails_q <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_next;
      rails_q <= rails_for(state_next);
      ready_q <= (state_next == S_RUN);
      if (lock_fault) begin
        fault_q <= 1'b1;
      end else if (entering && (state_next == S_VDD)) begin
        fault_q <= 1'b0;
      end
    end
  end

`ifdef BACKLIGHT_PWM_EN
  lcd_backlight_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_backlight_pwm (
    .clk        (clk),
    .rst        (rst),
    .brightness (bus.brightness),
    .led_en     (rails_q.led),
    .led_pwm    (led_pwm_w)
  );
`else
  // Without PWM the backlight runs at full brightness whenever enabled.
  logic unused_brightness;
  assign unused_brightness = ^bus.brightness;
  assign led_pwm_w         = rails_q.led;
`endif

  assign bus.panel_vdd_en = rails_q.vdd;
  assign bus.video_en     = rails_q.video;
  assign bus.led_en       = rails_q.led;
  assign bus.led_pwm      = led_pwm_w;
  assign bus.ready        = ready_q;
  assign bus.fault        = fault_q;
  assign bus.state_o      = state;

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lcd_power_sequencer
//   Directed bench for lcd_power_sequencer with short delays (TICK_DIV=10).
//   A timestamp-based model of the sequencing rules predicts every output on
//   every cycle; directed phases pin exact edge counts with literal values.
//   PWM expectations follow BACKLIGHT_PWM_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_lcd_power_sequencer;

  localparam int TICK_DIV   = 10;
  localparam int T_VDD_MS   = 2;
  localparam int T_VIDEO_MS = 3;
  localparam int T_BL_MS    = 3;
  localparam int T_PWR_MS   = 2;
  localparam int T_OFF_MS   = 5;
  localparam int PWM_BITS   = 8;
  localparam int PWM_PERIOD = 1 << PWM_BITS;

  // State codes as published on state_o
  localparam int M_OFF    = 0;
  localparam int M_VDD    = 1;
  localparam int M_VID    = 2;
  localparam int M_RUN    = 3;
  localparam int M_BLOFF  = 4;
  localparam int M_VIDOFF = 5;
  localparam int M_HOLD   = 6;

  logic clk          = 1'b0;
  logic rst          = 1'b1;
  logic gen_pulse    = 1'b0;
  logic manual_pulse = 1'b0;
  logic frame_run    = 1'b0;
  logic check_en     = 1'b0;
  int   fcnt         = 0;

  int dir_checks = 0;
  int dir_fails  = 0;
  int cyc_checks = 0;
  int cyc_fails  = 0;

  lcd_power_sequencer_if #(.PWM_BITS(PWM_BITS)) bus ();

  assign bus.frame_start = gen_pulse | manual_pulse;

  lcd_power_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .T_VDD_MS   (T_VDD_MS),
    .T_VIDEO_MS (T_VIDEO_MS),
    .T_BL_MS    (T_BL_MS),
    .T_PWR_MS   (T_PWR_MS),
    .T_OFF_MS   (T_OFF_MS),
    .PWM_BITS   (PWM_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Frame pulse source: one pulse every 50 clk while frame_run is set
  always @(negedge clk) begin
    if (!frame_run) begin
      fcnt      = 0;
      gen_pulse = 1'b0;
    end else begin
      fcnt      = (fcnt == 49) ? 0 : fcnt + 1;
      gen_pulse = (fcnt == 0);
    end
  end

  // ---------------- reference model ----------------
  int m_state     = M_OFF;
  int m_entry     = 0;
  int m_edges     = 0;
  int m_pwm_edges = 0;
  int m_duty      = 0;
  bit m_fault     = 1'b0;

  function automatic int delay_edges(input int t_ms);
    return (t_ms == 0) ? 1 : t_ms * TICK_DIV;
  endfunction

  // Elapsed time is edges since the entry timestamp; state codes are the
  // published encodings. PWM position is simply edges since reset.
  always @(posedge clk or negedge rst) begin : model
    int nxt;
    int since;
    if (!rst) begin
      m_state     = M_OFF;
      m_entry     = 0;
      m_edges     = 0;
      m_pwm_edges = 0;
      m_duty      = 0;
      m_fault     = 1'b0;
    end else begin
      m_edges++;
      since = m_edges - m_entry;
      nxt   = m_state;
      if ((m_state == M_VID || m_state == M_RUN || m_state == M_BLOFF) && !bus.lock) begin
        nxt     = M_VIDOFF;
        m_fault = 1'b1;
      end else if (m_state == M_OFF) begin
        if (bus.enable_req && bus.lock) nxt = M_VDD;
      end else if (m_state == M_VDD) begin
        if (!bus.lock || !bus.enable_req) nxt = M_VIDOFF;
        else if (since >= delay_edges(T_VDD_MS)) nxt = M_VID;
      end else if (m_state == M_VID) begin
        if (!bus.enable_req) nxt = M_VIDOFF;
        else if (bus.frame_start && since >= delay_edges(T_VIDEO_MS)) nxt = M_RUN;
      end else if (m_state == M_RUN) begin
        if (!bus.enable_req) nxt = M_BLOFF;
      end else if (m_state == M_BLOFF) begin
        if (since >= delay_edges(T_BL_MS)) nxt = M_VIDOFF;
      end else if (m_state == M_VIDOFF) begin
        if (since >= delay_edges(T_PWR_MS)) nxt = M_HOLD;
      end else begin
        if (since >= delay_edges(T_OFF_MS)) nxt = M_OFF;
      end
      if (nxt == M_VDD && m_state != M_VDD) m_fault = 1'b0;
      if (nxt != m_state) m_entry = m_edges;
      m_state = nxt;
      m_pwm_edges++;
      if ((m_pwm_edges % PWM_PERIOD) == 0) m_duty = int'(bus.brightness);
    end
  end

  // Per-cycle comparison of all outputs against the model, plus the
  // rail ordering invariant
  always @(negedge clk) begin : compare
    logic       e_vdd, e_vid, e_led, e_pwm, e_ready;
    logic [8:0] exp_v, act_v;
    if (check_en) begin
      e_vdd   = (m_state >= M_VDD && m_state <= M_VIDOFF);
      e_vid   = (m_state == M_VID || m_state == M_RUN || m_state == M_BLOFF);
      e_led   = (m_state == M_RUN);
      e_ready = (m_state == M_RUN);
`ifdef BACKLIGHT_PWM_EN
      e_pwm   = e_led && ((m_pwm_edges % PWM_PERIOD) < m_duty);
`else
      e_pwm   = e_led;
`endif
      exp_v = {e_vdd, e_vid, e_led, e_pwm, e_ready, m_fault, 3'(m_state)};
      act_v = {bus.panel_vdd_en, bus.video_en, bus.led_en, bus.led_pwm,
               bus.ready, bus.fault, bus.state_o};
      cyc_checks++;
      if (act_v !== exp_v) begin
        cyc_fails++;
        if (cyc_fails <= 20)
          $display("[TB] FAIL cycle_model t=%0t actual=%b required=%b (vdd,vid,led,pwm,rdy,flt,state)",
                   $time, act_v, exp_v);
      end
      cyc_checks++;
      if ((bus.led_en && !bus.video_en) || (bus.video_en && !bus.panel_vdd_en)) begin
        cyc_fails++;
        if (cyc_fails <= 20)
          $display("[TB] FAIL rail_order t=%0t actual vdd/vid/led=%b%b%b required ordered",
                   $time, bus.panel_vdd_en, bus.video_en, bus.led_en);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check_output(input string name, input int actual, input int required);
    dir_checks++;
    if (actual != required) begin
      dir_fails++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic lk);
    @(negedge clk);
    bus.enable_req = en;
    bus.lock       = lk;
  endtask

  // Counts posedges until the chosen rail (0 vdd, 1 video, 2 led) equals val
  task automatic wait_for(input string name, input int which, input logic val,
                          input int limit, output int n);
    logic s;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      case (which)
        0:       s = bus.panel_vdd_en;
        1:       s = bus.video_en;
        default: s = bus.led_en;
      endcase
    end while (s !== val && n < limit);
    if (s !== val) begin
      dir_checks++;
      dir_fails++;
      $display("[TB] FAIL %s timeout actual=%b required=%b after %0d clk", name, s, val, n);
    end
  endtask

  // High cycles of led_pwm over one full PWM period starting at a wrap
  task automatic count_pwm_window(output int highs);
    int guard;
    guard = 0;
    highs = 0;
    while ((m_pwm_edges % PWM_PERIOD) != 0 && guard < 2 * PWM_PERIOD) begin
      @(posedge clk);
      #1;
      guard++;
    end
    for (int i = 0; i < PWM_PERIOD; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      highs += int'(bus.led_pwm);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int highs;
    bus.enable_req = 1'b0;
    bus.lock       = 1'b1;
    bus.brightness = 8'd64;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_outputs", int'({bus.panel_vdd_en, bus.video_en, bus.led_en,
                                        bus.led_pwm, bus.ready, bus.fault}), 0);
    check_output("reset_state", int'(bus.state_o), 0);
    rst       = 1'b1;
    check_en  = 1'b1;
    frame_run = 1'b1;

    // Power-up
    apply_stimulus(1'b1, 1'b1);
    wait_for("vdd_on", 0, 1'b1, 5, n);
    check_output("vdd_on_delay", n, 1);
    wait_for("video_on", 1, 1'b1, 40, n);
    check_output("video_on_delay", n, 20);
    wait_for("led_on", 2, 1'b1, 100, n);
    check_output("led_on_window", int'(n >= 30 && n < 80), 1);
    check_output("ready_with_led", int'(bus.ready), 1);

    // Backlight PWM
    count_pwm_window(highs);
`ifdef BACKLIGHT_PWM_EN
    check_output("pwm_duty_64", highs, 64);
`else
    check_output("pwm_follows_led", highs, 256);
`endif
    repeat (100) @(negedge clk);
    bus.brightness = 8'd128;
    count_pwm_window(highs);
`ifdef BACKLIGHT_PWM_EN
    check_output("pwm_duty_128", highs, 128);
`else
    check_output("pwm_follows_led_2", highs, 256);
`endif
    @(negedge clk);
    bus.brightness = 8'd0;
    count_pwm_window(highs);
`ifdef BACKLIGHT_PWM_EN
    check_output("pwm_duty_0", highs, 0);
`else
    check_output("pwm_follows_led_3", highs, 256);
`endif
    bus.brightness = 8'd200;

    // Orderly power-down, then re-request during the hold-off
    apply_stimulus(1'b0, 1'b1);
    wait_for("led_off", 2, 1'b0, 5, n);
    check_output("led_off_delay", n, 1);
    check_output("ready_drop", int'(bus.ready), 0);
    wait_for("video_off", 1, 1'b0, 60, n);
    check_output("video_off_delay", n, 30);
    wait_for("vdd_off", 0, 1'b0, 40, n);
    check_output("vdd_off_delay", n, 20);
    apply_stimulus(1'b1, 1'b1);
    wait_for("vdd_repower", 0, 1'b1, 100, n);
    check_output("hold_repower_delay", n, 51);

    // Lock loss while running
    wait_for("video_on_2", 1, 1'b1, 40, n);
    check_output("video_on_delay_2", n, 20);
    wait_for("led_on_2", 2, 1'b1, 100, n);
    check_output("led_on_window_2", int'(n >= 30 && n < 80), 1);
    apply_stimulus(1'b1, 1'b0);
    wait_for("led_lockloss", 2, 1'b0, 5, n);
    check_output("led_lockloss_delay", n, 1);
    check_output("video_lockloss_same_edge", int'(bus.video_en), 0);
    check_output("fault_set", int'(bus.fault), 1);
    wait_for("vdd_lockloss", 0, 1'b0, 40, n);
    check_output("vdd_lockloss_delay", n, 20);
    repeat (60) @(negedge clk);
    check_output("fault_held", int'(bus.fault), 1);
    check_output("off_waits_for_lock", int'(bus.state_o), M_OFF);
    apply_stimulus(1'b1, 1'b1);
    wait_for("vdd_relock", 0, 1'b1, 5, n);
    check_output("vdd_relock_delay", n, 1);
    check_output("fault_cleared", int'(bus.fault), 0);

    // Lock loss during VDD ramp: shutdown without fault
    apply_stimulus(1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_output("vdd_lockloss_state", int'(bus.state_o), M_VIDOFF);
    check_output("vdd_lockloss_no_fault", int'(bus.fault), 0);
    apply_stimulus(1'b0, 1'b1);
    wait_for("vdd_off_3", 0, 1'b0, 40, n);
    check_output("vdd_off_delay_3", n, 20);
    repeat (55) @(negedge clk);

    // Abort beats a qualifying frame_start in S_VID
    frame_run = 1'b0;
    apply_stimulus(1'b1, 1'b1);
    wait_for("vdd_on_4", 0, 1'b1, 5, n);
    wait_for("video_on_4", 1, 1'b1, 40, n);
    check_output("video_on_delay_4", n, 20);
    repeat (40) @(negedge clk);
    bus.enable_req = 1'b0;
    manual_pulse   = 1'b1;
    @(posedge clk);
    #1;
    check_output("abort_state", int'(bus.state_o), M_VIDOFF);
    check_output("abort_led", int'(bus.led_en), 0);
    @(negedge clk);
    manual_pulse = 1'b0;
    wait_for("vdd_off_4", 0, 1'b0, 40, n);
    check_output("vdd_off_delay_4", n, 20);
    repeat (55) @(negedge clk);

    // Asynchronous reset while running
    frame_run = 1'b1;
    apply_stimulus(1'b1, 1'b1);
    wait_for("vdd_on_5", 0, 1'b1, 5, n);
    wait_for("video_on_5", 1, 1'b1, 40, n);
    wait_for("led_on_5", 2, 1'b1, 100, n);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("async_reset_outputs", int'({bus.panel_vdd_en, bus.video_en, bus.led_en,
                                              bus.led_pwm, bus.ready, bus.fault}), 0);
    check_output("async_reset_state", int'(bus.state_o), 0);
    @(negedge clk);
    bus.enable_req = 1'b0;
    rst            = 1'b1;
    repeat (5) @(negedge clk);
    check_output("post_reset_idle", int'(bus.state_o), M_OFF);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", dir_checks + cyc_checks, dir_fails + cyc_fails);
    $finish;
  end

endmodule
